fir_sample_fifo: RTL and testbench

Input sample buffer sitting directly upstream of the FIR control FSM and multiplier datapath.
- Accepts one sample per PushIn.
- Exposes fifo_empty to the control FSM.
- Returns the oldest sample one cycle after each fifoPullOut, in time for the FSM's WaitForData phase.
- Provides full/level status and sticky overflow/underflow error flags for the system wrapper.

---
 rtl/fir_structs.sv | 18 +
 rtl/fir_sample_fifo_if.sv | 32 +++
 rtl/fir_fifo_mem.sv | 28 ++
 rtl/fir_sample_fifo.sv | 76 +++++++
 tb/tb_fir_sample_fifo.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_structs.sv
// Shared types and default sizing for the FIR sample buffer and its system wrapper.
package fir_structs;

  localparam int FIFO_DEPTH = 8;
  localparam int SAMPLE_W   = 32;
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef struct packed {
    logic   full;
    logic   empty;
    level_t level;
    logic   overflow;
    logic   underflow;
  } fifo_status_t;

endpackage

// File: rtl/fir_sample_fifo_if.sv
// Handshake and status bundle between the sample producer/FIR control FSM and the sample FIFO.
interface fir_sample_fifo_if
  import fir_structs::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = FIFO_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     PushIn;
  logic signed [DATA_W-1:0] DataIn;
  logic                     fifoPullOut;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [ADDR_W:0]          level;
  logic signed [DATA_W-1:0] DataOut;
  logic                     DataOutValid;
  logic                     overflow;
  logic                     underflow;
  fifo_status_t             status;

  modport master (
    output PushIn, DataIn, fifoPullOut,
    input  fifo_empty, fifo_full, level, DataOut, DataOutValid, overflow, underflow, status
  );

  modport slave (
    input  PushIn, DataIn, fifoPullOut,
    output fifo_empty, fifo_full, level, DataOut, DataOutValid, overflow, underflow, status
  );

endinterface

// File: rtl/fir_fifo_mem.sv
// DEPTH x DATA_W sample storage: one write port, one enable-gated registered read port.
module fir_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic signed [DATA_W-1:0]   wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic signed [DATA_W-1:0]   rd_data_p1
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // p0 -> p1: read register; only the output holds a reset value, storage does not
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data_p1 <= '0;
    else if (rd_en) rd_data_p1 <= mem[rd_addr];
  end

endmodule

// File: rtl/fir_sample_fifo.sv
// Input sample buffer ahead of the FIR control FSM: wrap-bit pointers, 1-cycle read, sticky error flags.
module fir_sample_fifo
  import fir_structs::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  fir_sample_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            full;
  logic            empty;
  logic            push_acc;
  logic            pull_acc;
  logic            vld_p1;
  logic            overflow;
  logic            underflow;

  // Status comes only from registered pointers, keeping strobes off every output path
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // A pull frees a slot in the same cycle, so a full FIFO still accepts a paired push
  assign push_acc = bus.PushIn & (~full | bus.fifoPullOut);
  assign pull_acc = bus.fifoPullOut & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      vld_p1    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pull_acc) rd_ptr <= rd_ptr + 1'b1;
      vld_p1 <= pull_acc;
      if (bus.PushIn & full & ~bus.fifoPullOut) overflow  <= 1'b1;
      if (bus.fifoPullOut & empty)              underflow <= 1'b1;
    end
  end

  fir_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (push_acc),
    .wr_addr    (wr_ptr[ADDR_W-1:0]),
    .wr_data    (bus.DataIn),
    .rd_en      (pull_acc),
    .rd_addr    (rd_ptr[ADDR_W-1:0]),
    .rd_data_p1 (bus.DataOut)
  );

  assign bus.fifo_empty   = empty;
  assign bus.fifo_full    = full;
  assign bus.level        = wr_ptr - rd_ptr;
  assign bus.DataOutValid = vld_p1;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

  assign bus.status.full      = full;
  assign bus.status.empty     = empty;
  assign bus.status.level     = level_t'(wr_ptr - rd_ptr);
  assign bus.status.overflow  = overflow;
  assign bus.status.underflow = underflow;

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Directed bench for fir_sample_fifo: queue-based reference model checked every cycle plus literal spot checks.
module tb_fir_sample_fifo;
  import fir_structs::*;

  localparam int DW = 32;
  localparam int DP = 8;

  logic clk;
  logic reset_n;
  logic run;
  int   checks;
  int   errors;

  fir_sample_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  fir_sample_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus the registered outputs
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Apply one cycle of stimulus and advance the model at the clock edge
  task automatic step(input logic p, input logic [DW-1:0] d, input logic q);
    logic was_full;
    logic was_empty;
    bus.PushIn      = p;
    bus.DataIn      = d;
    bus.fifoPullOut = q;
    @(posedge clk);
    if (reset_n) begin
      was_full  = (m_q.size() == DP);
      was_empty = (m_q.size() == 0);
      if (p && was_full && !q) m_ovf = 1'b1;
      if (q && was_empty)      m_unf = 1'b1;
      m_valid = q && !was_empty;
      if (q && !was_empty) m_dout = m_q.pop_front();
      if (p && (!was_full || q)) m_q.push_back(d);
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    step(0, '0, 0);
    step(0, '0, 0);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("empty",  {31'b0, bus.fifo_empty},   {31'b0, m_q.size() == 0});
      chk("full",   {31'b0, bus.fifo_full},    {31'b0, m_q.size() == DP});
      chk("level",  {28'b0, bus.level},        m_q.size());
      chk("valid",  {31'b0, bus.DataOutValid}, {31'b0, m_valid});
      chk("dout",   bus.DataOut,               m_dout);
      chk("ovf",    {31'b0, bus.overflow},     {31'b0, m_ovf});
      chk("unf",    {31'b0, bus.underflow},    {31'b0, m_unf});
      chk("st_lvl", {28'b0, bus.status.level}, m_q.size());
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    run = 1'b0;
    reset_n = 1'b0;
    bus.PushIn = 1'b0;
    bus.DataIn = '0;
    bus.fifoPullOut = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run = 1'b1;

    // Idle after reset
    repeat (5) step(0, '0, 0);
    chk("rst_empty", {31'b0, bus.fifo_empty}, 32'd1);
    chk("rst_full",  {31'b0, bus.fifo_full},  32'd0);
    chk("rst_level", {28'b0, bus.level},      32'd0);
    chk("rst_valid", {31'b0, bus.DataOutValid}, 32'd0);
    chk("rst_ovf",   {31'b0, bus.overflow},   32'd0);
    chk("rst_unf",   {31'b0, bus.underflow},  32'd0);

    // Three pushes, three pulls
    step(1, 32'h11, 0);
    step(1, 32'h22, 0);
    step(1, 32'h33, 0);
    chk("t2_level3", {28'b0, bus.level}, 32'd3);
    step(0, '0, 1);
    chk("t2_dout0", bus.DataOut, 32'h11);
    chk("t2_vld0",  {31'b0, bus.DataOutValid}, 32'd1);
    chk("t2_level2", {28'b0, bus.level}, 32'd2);
    step(0, '0, 1);
    chk("t2_dout1", bus.DataOut, 32'h22);
    chk("t2_level1", {28'b0, bus.level}, 32'd1);
    step(0, '0, 1);
    chk("t2_dout2", bus.DataOut, 32'h33);
    chk("t2_level0", {28'b0, bus.level}, 32'd0);
    chk("t2_empty", {31'b0, bus.fifo_empty}, 32'd1);
    step(0, '0, 0);
    chk("t2_vld_off", {31'b0, bus.DataOutValid}, 32'd0);
    chk("t2_dout_hold", bus.DataOut, 32'h33);

    // Fill, then overflow
    for (int i = 0; i < 8; i++) step(1, i, 0);
    step(1, 32'hFF, 0);
    chk("t3_full",  {31'b0, bus.fifo_full}, 32'd1);
    chk("t3_ovf",   {31'b0, bus.overflow},  32'd1);
    chk("t3_level", {28'b0, bus.level},     32'd8);
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1);
      chk("t3_drain", bus.DataOut, i);
    end
    step(0, '0, 1);
    chk("t3_no_ff_vld", {31'b0, bus.DataOutValid}, 32'd0);
    chk("t3_dout_hold", bus.DataOut, 32'h07);

    // Push and pull together while full
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 32'h10 + i, 0);
    step(1, 32'hA5, 1);
    chk("t4_level", {28'b0, bus.level}, 32'd8);
    chk("t4_dout",  bus.DataOut, 32'h10);
    chk("t4_ovf",   {31'b0, bus.overflow}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      step(0, '0, 1);
      chk("t4_drain", bus.DataOut, 32'h10 + i);
    end
    step(0, '0, 1);
    chk("t4_last", bus.DataOut, 32'hA5);

    // Pull on empty with a same-cycle push
    step(1, 32'h5A, 1);
    chk("t5_vld",   {31'b0, bus.DataOutValid}, 32'd0);
    chk("t5_unf",   {31'b0, bus.underflow},    32'd1);
    chk("t5_level", {28'b0, bus.level},        32'd1);
    step(0, '0, 1);
    chk("t5_dout",  bus.DataOut, 32'h5A);
    chk("t5_vld2",  {31'b0, bus.DataOutValid}, 32'd1);

    // Streaming across the pointer wrap, then asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h100 + i, i > 0);
      if (i > 0) begin
        chk("t6_dout",  bus.DataOut, 32'h100 + i - 1);
        chk("t6_level", {28'b0, bus.level}, 32'd1);
      end
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_ar_vld",   {31'b0, bus.DataOutValid}, 32'd0);
    chk("t6_ar_dout",  bus.DataOut, 32'd0);
    chk("t6_ar_level", {28'b0, bus.level}, 32'd0);
    chk("t6_ar_empty", {31'b0, bus.fifo_empty}, 32'd1);
    step(0, '0, 0);
    step(0, '0, 0);
    reset_n = 1'b1;
    step(1, 32'h201, 0);
    step(1, 32'h202, 0);
    step(1, 32'h203, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, '0, 1);
      chk("t6_post", bus.DataOut, 32'h200 + i);
    end
    step(0, '0, 0);
    chk("t6_post_empty", {31'b0, bus.fifo_empty}, 32'd1);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
